// File: rtl/otter_mem_responder.sv
// otter_mem_responder
//
// Memory-side responder for the multicycle OTTER CPU. Accepts one request at a
// time from either the instruction-fetch port (port 1) or the data load/store
// port (port 2). Routes each request to the external word SRAM (req/ack
// handshake) or the memory-mapped IO bus, and answers with a one-cycle
// completion pulse on the requesting port. Byte-lane steering, load sign/zero
// extension and alignment/range fault detection are done here.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   memRDEN1, memAddr1    fetch request / byte address
//   memIR, memValid1      fetched word (held) / one-cycle fetch completion
//   memRDEN2, memWE2      data read / write request (write wins if both set)
//   memAddr2, memDin2     data byte address / right-aligned store data
//   memSize, memSign      0 byte, 1 half, 2 word, 3 illegal / 1 = zero-extend
//   memDout2, memValid2   load result (held) / one-cycle data completion
//   memErr                high in the completion cycle of a faulted access
//   sramReq .. sramWdata  SRAM request, held stable until sramAck
//   sramAck, sramRdata    SRAM completion and same-cycle read data
//   ioWr, ioAddr, ioOut   one-cycle IO write strobe, byte address, full word
//   ioIn                  IO read data
module otter_mem_responder #(
  parameter int          ADDR_W  = 14,
  parameter logic [31:0] IO_BASE = 32'h1100_0000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              memRDEN1,
  input  logic [31:0]       memAddr1,
  output logic [31:0]       memIR,
  output logic              memValid1,
  input  logic              memRDEN2,
  input  logic              memWE2,
  input  logic [31:0]       memAddr2,
  input  logic [31:0]       memDin2,
  input  logic [1:0]        memSize,
  input  logic              memSign,
  output logic [31:0]       memDout2,
  output logic              memValid2,
  output logic              memErr,
  output logic              sramReq,
  output logic              sramWe,
  output logic [ADDR_W-1:0] sramAddr,
  output logic [3:0]        sramBe,
  output logic [31:0]       sramWdata,
  input  logic              sramAck,
  input  logic [31:0]       sramRdata,
  output logic              ioWr,
  output logic [31:0]       ioAddr,
  output logic [31:0]       ioOut,
  input  logic [31:0]       ioIn
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic        cur_p2;
  logic        cur_we;
  logic        cur_sign;
  logic        cur_fault;
  logic        cur_io;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] ir_q;
  logic [31:0] dout_q;

  logic        sel_p2;
  logic        any_req;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_io;
  logic        req_fault;

  // Pick the winning requester (port 2 first) and classify its access.
  // Fetches are always treated as word accesses for the alignment check.
  always_comb begin
    sel_p2    = memRDEN2 | memWE2;
    any_req   = sel_p2 | memRDEN1;
    req_addr  = sel_p2 ? memAddr2 : memAddr1;
    req_size  = sel_p2 ? memSize : 2'd2;
    req_io    = (req_addr >= IO_BASE);
    req_fault = 1'b0;
    case (req_size)
      2'd1:    if (req_addr[0]) req_fault = 1'b1;
      2'd2:    if (req_addr[1:0] != 2'b00) req_fault = 1'b1;
      2'd3:    req_fault = 1'b1;
      default: ;
    endcase
    if (!sel_p2 && req_io) req_fault = 1'b1;
    // SRAM-region addresses must fit in the physical SRAM
    if (!req_io && ((req_addr >> (ADDR_W + 2)) != 32'd0)) req_fault = 1'b1;
  end

  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted;
  logic [31:0] load_c;

  // Lane steering for stores and right-alignment plus extension for loads.
  // Store data is replicated so the enabled lanes always see the right bytes.
  always_comb begin
    case (cur_size)
      2'd0: begin
        be_c    = 4'b0001 << cur_addr[1:0];
        wdata_c = {4{cur_wdata[7:0]}};
      end
      2'd1: begin
        be_c    = 4'b0011 << cur_addr[1:0];
        wdata_c = {2{cur_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = cur_wdata;
      end
    endcase
    shifted = sramRdata >> {cur_addr[1:0], 3'b000};
    case (cur_size)
      2'd0:    load_c = cur_sign ? {24'd0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_c = cur_sign ? {16'd0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: load_c = shifted;
    endcase
  end

  // Request/response sequencer. Faults and IO accesses skip the SRAM and
  // complete one cycle after acceptance; a fault zeroes the port's result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cur_p2    <= 1'b0;
      cur_we    <= 1'b0;
      cur_sign  <= 1'b0;
      cur_fault <= 1'b0;
      cur_io    <= 1'b0;
      cur_size  <= 2'd0;
      cur_addr  <= 32'd0;
      cur_wdata <= 32'd0;
      ir_q      <= 32'd0;
      dout_q    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            cur_p2    <= sel_p2;
            cur_we    <= memWE2;
            cur_sign  <= memSign;
            cur_fault <= req_fault;
            cur_io    <= req_io;
            cur_size  <= req_size;
            cur_addr  <= req_addr;
            cur_wdata <= memDin2;
            if (req_fault) begin
              if (sel_p2) dout_q <= 32'd0;
              else        ir_q   <= 32'd0;
              state <= ST_RESP;
            end else if (req_io) begin
              state <= ST_RESP;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (sramAck) begin
            if (!cur_p2)      ir_q   <= sramRdata;
            else if (!cur_we) dout_q <= load_c;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          // IO load data is latched at the end of the completion cycle
          if (cur_p2 && cur_io && !cur_we && !cur_fault) dout_q <= ioIn;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic in_req;
  logic in_resp;
  logic io_access;
  logic io_load;

  // Output decode; SRAM fields are only driven while a request is pending.
  always_comb begin
    in_req    = (state == ST_REQ);
    in_resp   = (state == ST_RESP);
    io_access = cur_p2 & cur_io & ~cur_fault;
    io_load   = in_resp & io_access & ~cur_we;

    sramReq   = in_req;
    sramWe    = in_req & cur_we;
    sramAddr  = in_req ? cur_addr[ADDR_W+1:2] : '0;
    sramBe    = in_req ? be_c : 4'd0;
    sramWdata = (in_req & cur_we) ? wdata_c : 32'd0;

    memValid1 = in_resp & ~cur_p2;
    memValid2 = in_resp & cur_p2;
    memErr    = in_resp & cur_fault;
    memIR     = ir_q;
    // Show the IO read value during the completion cycle, then hold the latch
    memDout2  = io_load ? ioIn : dout_q;

    ioWr      = in_resp & io_access & cur_we;
    ioAddr    = io_access ? cur_addr : 32'd0;
    ioOut     = io_access ? cur_wdata : 32'd0;
  end

endmodule

// File: tb/tb_otter_mem_responder.sv
// tb_otter_mem_responder
//
// Directed and randomized checks of otter_mem_responder. A behavioural SRAM
// answers requests after a programmable delay; expected results come from a
// byte-addressed memory image and the access rules (alignment, range, IO).
module tb_otter_mem_responder;

  localparam int          ADDR_W    = 14;
  localparam logic [31:0] IO_BASE   = 32'h1100_0000;
  localparam int          MEM_WORDS = 1 << ADDR_W;
  localparam int          MEM_BYTES = 4 << ADDR_W;

  logic              CLK;
  logic              RST_N;
  logic              memRDEN1;
  logic [31:0]       memAddr1;
  logic [31:0]       memIR;
  logic              memValid1;
  logic              memRDEN2;
  logic              memWE2;
  logic [31:0]       memAddr2;
  logic [31:0]       memDin2;
  logic [1:0]        memSize;
  logic              memSign;
  logic [31:0]       memDout2;
  logic              memValid2;
  logic              memErr;
  logic              sramReq;
  logic              sramWe;
  logic [ADDR_W-1:0] sramAddr;
  logic [3:0]        sramBe;
  logic [31:0]       sramWdata;
  logic              sramAck;
  logic [31:0]       sramRdata;
  logic              ioWr;
  logic [31:0]       ioAddr;
  logic [31:0]       ioOut;
  logic [31:0]       ioIn;

  int checks = 0;
  int errors = 0;

  // SRAM environment state and observations
  int                ack_delay = 0;
  int                req_cycles = 0;
  int                io_wr_cycles = 0;
  int                unstable = 0;
  int                s_wait = 0;
  logic              s_active = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [3:0]        last_be = '0;
  logic              last_we = 1'b0;
  logic [31:0]       last_wdata = '0;
  logic [31:0]       sram [0:MEM_WORDS-1];

  // Reference byte image of the SRAM
  logic [7:0]        mbytes [0:MEM_BYTES-1];

  otter_mem_responder #(.ADDR_W(ADDR_W), .IO_BASE(IO_BASE)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .memRDEN1(memRDEN1), .memAddr1(memAddr1), .memIR(memIR), .memValid1(memValid1),
    .memRDEN2(memRDEN2), .memWE2(memWE2), .memAddr2(memAddr2), .memDin2(memDin2),
    .memSize(memSize), .memSign(memSign), .memDout2(memDout2), .memValid2(memValid2),
    .memErr(memErr),
    .sramReq(sramReq), .sramWe(sramWe), .sramAddr(sramAddr), .sramBe(sramBe),
    .sramWdata(sramWdata), .sramAck(sramAck), .sramRdata(sramRdata),
    .ioWr(ioWr), .ioAddr(ioAddr), .ioOut(ioOut), .ioIn(ioIn)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural SRAM: acks after ack_delay extra request cycles and records
  // the request fields so stability and lane steering can be inspected.
  initial begin
    sramAck   = 1'b0;
    sramRdata = 32'd0;
    forever begin
      @(negedge CLK);
      sramAck = 1'b0;
      if (!RST_N || !sramReq) begin
        s_active = 1'b0;
        s_wait   = 0;
      end else begin
        req_cycles++;
        if (s_active && (sramAddr != last_addr || sramBe != last_be ||
                         sramWe != last_we || sramWdata != last_wdata))
          unstable++;
        s_active   = 1'b1;
        last_addr  = sramAddr;
        last_be    = sramBe;
        last_we    = sramWe;
        last_wdata = sramWdata;
        if (s_wait >= ack_delay) begin
          sramAck = 1'b1;
          if (sramWe) begin
            for (int k = 0; k < 4; k++)
              if (sramBe[k]) sram[sramAddr][8*k +: 8] = sramWdata[8*k +: 8];
          end else begin
            sramRdata = sram[sramAddr];
          end
        end else begin
          s_wait++;
        end
      end
      if (ioWr) io_wr_cycles++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic setWord(input int widx, input logic [31:0] val);
    sram[widx] = val;
    for (int k = 0; k < 4; k++) mbytes[4*widx + k] = val[8*k +: 8];
  endtask

  function automatic logic [31:0] modelLoad(input logic [31:0] addr, input int nbytes,
                                            input logic zext);
    logic [31:0] v;
    logic [15:0] idx;
    v = 32'd0;
    for (int k = 0; k < nbytes; k++) begin
      idx = 16'(addr + 32'(k));
      v   = v | (32'(mbytes[idx]) << (8*k));
    end
    if (!zext && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'd1 << (8*nbytes)) - 32'd1);
    return v;
  endfunction

  task automatic modelStore(input logic [31:0] addr, input int nbytes, input logic [31:0] din);
    logic [15:0] idx;
    for (int k = 0; k < nbytes; k++) begin
      idx         = 16'(addr + 32'(k));
      mbytes[idx] = din[8*k +: 8];
    end
  endtask

  function automatic logic expFault(input logic p2, input logic [31:0] addr, input logic [1:0] size);
    int nb;
    if (p2 && size == 2'd3) return 1'b1;
    nb = p2 ? (1 << size) : 4;
    if ((addr % 32'(nb)) != 32'd0) return 1'b1;
    if (addr >= IO_BASE) return !p2;
    return addr >= 32'(MEM_BYTES);
  endfunction

  // Drive one request, wait (bounded) for its completion pulse, release it,
  // and sample the port once more in the following cycle.
  task automatic applyStimulus(input logic p2, input logic rd, input logic we,
                               input logic [31:0] addr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] din,
                               output logic [31:0] res, output logic [31:0] held,
                               output logic err, output int cyc, output logic otherv,
                               output logic io_w, output logic [31:0] io_a,
                               output logic [31:0] io_d);
    logic done;
    res = '0; held = '0; err = 1'b0; otherv = 1'b0;
    io_w = 1'b0; io_a = '0; io_d = '0; done = 1'b0; cyc = 0;
    @(negedge CLK);
    if (p2) begin
      memRDEN2 = rd; memWE2 = we; memAddr2 = addr;
      memSize = size; memSign = sgn; memDin2 = din;
    end else begin
      memRDEN1 = 1'b1; memAddr1 = addr;
    end
    while (!done && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (p2 ? memValid2 : memValid1) begin
        done   = 1'b1;
        res    = p2 ? memDout2 : memIR;
        err    = memErr;
        otherv = p2 ? memValid1 : memValid2;
        io_w   = ioWr;
        io_a   = ioAddr;
        io_d   = ioOut;
      end
    end
    memRDEN1 = 1'b0; memRDEN2 = 1'b0; memWE2 = 1'b0;
    checkOutput("handshake_timeout", 32'(done), 32'd1);
    @(negedge CLK);
    checkOutput("valid_single_pulse", 32'({memValid1, memValid2}), 32'd0);
    held = p2 ? memDout2 : memIR;
  endtask

  // One complete access checked against the reference rules.
  task automatic doAccess(input string tag, input logic p2, input logic rd, input logic we,
                          input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] din, output logic [31:0] res);
    logic        fault, io, is_store, exp_iow, err, otherv, io_w;
    logic [31:0] exp_val, held, io_a, io_d;
    int          nb, exp_cyc, cyc;
    is_store = p2 && we;
    fault    = expFault(p2, addr, size);
    io       = p2 && (addr >= IO_BASE);
    nb       = (p2 && size != 2'd3) ? (1 << size) : 4;
    exp_cyc  = (fault || io) ? 1 : ack_delay + 2;
    if (fault)   exp_val = 32'd0;
    else if (io) exp_val = ioIn;
    else         exp_val = modelLoad(addr, nb, p2 ? sgn : 1'b1);
    exp_iow  = is_store && io && !fault;

    applyStimulus(p2, rd, we, addr, size, sgn, din, res, held, err, cyc, otherv, io_w, io_a, io_d);

    checkOutput({tag, "_err"}, 32'(err), 32'(fault));
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    checkOutput({tag, "_other_port"}, 32'(otherv), 32'd0);
    checkOutput({tag, "_iowr"}, 32'(io_w), 32'(exp_iow));
    if (exp_iow) begin
      checkOutput({tag, "_ioaddr"}, io_a, addr);
      checkOutput({tag, "_ioout"}, io_d, din);
    end
    if (!is_store || fault) begin
      if (!(io && !fault)) checkOutput({tag, "_data"}, res, exp_val);
      checkOutput({tag, "_held"}, held, exp_val);
    end
    if (is_store && !fault && !io) modelStore(addr, nb, din);
  endtask

  initial begin
    logic [31:0] res, addr, din;
    logic        p2, rd, we, sgn, got, saw_v1;
    logic [1:0]  size;
    int          cyc, cat;

    RST_N = 1'b0;
    memRDEN1 = 1'b0; memAddr1 = '0; memRDEN2 = 1'b0; memWE2 = 1'b0;
    memAddr2 = '0; memDin2 = '0; memSize = 2'd0; memSign = 1'b0; ioIn = '0;
    for (int i = 0; i < MEM_WORDS; i++) setWord(i, $urandom);

    // Reset state
    repeat (3) @(negedge CLK);
    checkOutput("rst_valids", 32'({memValid1, memValid2, memErr}), 32'd0);
    checkOutput("rst_sram", 32'({sramReq, sramWe, sramBe}), 32'd0);
    checkOutput("rst_sramaddr", 32'(sramAddr), 32'd0);
    checkOutput("rst_memIR", memIR, 32'd0);
    checkOutput("rst_memDout2", memDout2, 32'd0);
    checkOutput("rst_io", 32'(ioWr), 32'd0);
    RST_N = 1'b1;

    // First fetch, ack in the first REQ cycle
    setWord(4, 32'h0040_0093);
    ack_delay = 0;
    doAccess("fetch", 1'b0, 1'b0, 1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'd0, res);
    checkOutput("fetch_ir_value", res, 32'h0040_0093);
    checkOutput("fetch_sramaddr", 32'(last_addr), 32'd4);
    checkOutput("fetch_be", 32'(last_be), 32'hF);

    // Byte loads, signed and unsigned
    setWord(8, 32'h80FF_1234);
    doAccess("lb_signed", 1'b1, 1'b1, 1'b0, 32'h0000_0023, 2'd0, 1'b0, 32'd0, res);
    checkOutput("lb_signed_value", res, 32'hFFFF_FF80);
    checkOutput("lb_be", 32'(last_be), 32'b1000);
    doAccess("lbu", 1'b1, 1'b1, 1'b0, 32'h0000_0023, 2'd0, 1'b1, 32'd0, res);
    checkOutput("lbu_value", res, 32'h0000_0080);

    // Half store with delayed ack
    setWord(64, 32'h0123_4567);
    ack_delay = 3;
    unstable  = 0;
    doAccess("sh", 1'b1, 1'b0, 1'b1, 32'h0000_0102, 2'd1, 1'b0, 32'hDEAD_BEEF, res);
    checkOutput("sh_we", 32'(last_we), 32'd1);
    checkOutput("sh_be", 32'(last_be), 32'b1100);
    checkOutput("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    checkOutput("sh_sramaddr", 32'(last_addr), 32'h40);
    checkOutput("sh_stable", 32'(unstable), 32'd0);
    ack_delay = 0;
    doAccess("sh_readback", 1'b1, 1'b1, 1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'd0, res);
    checkOutput("sh_readback_value", res, 32'hBEEF_4567);

    // Misaligned word load faults without touching the SRAM
    req_cycles = 0;
    doAccess("lw_misaligned", 1'b1, 1'b1, 1'b0, 32'h0000_0006, 2'd2, 1'b0, 32'd0, res);
    checkOutput("lw_misaligned_no_sram", 32'(req_cycles), 32'd0);

    // IO store and load
    io_wr_cycles = 0;
    doAccess("io_store", 1'b1, 1'b0, 1'b1, 32'h1100_00C0, 2'd2, 1'b0, 32'h0000_0005, res);
    checkOutput("io_store_strobe_cycles", 32'(io_wr_cycles), 32'd1);
    ioIn = 32'h8765_4321;
    doAccess("io_load", 1'b1, 1'b1, 1'b0, 32'h1100_0010, 2'd0, 1'b0, 32'd0, res);

    // Simultaneous fetch and data read: data port completes first
    setWord(16, 32'h1111_2222);
    setWord(32, 32'h3333_4444);
    @(negedge CLK);
    memRDEN1 = 1'b1; memAddr1 = 32'h40;
    memRDEN2 = 1'b1; memWE2 = 1'b0; memAddr2 = 32'h80; memSize = 2'd2; memSign = 1'b0;
    cyc = 0; got = 1'b0; saw_v1 = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge CLK);
      cyc++;
      if (memValid1) saw_v1 = 1'b1;
      if (memValid2) got = 1'b1;
    end
    checkOutput("prio_p2_done", 32'(got), 32'd1);
    checkOutput("prio_p2_latency", 32'(cyc), 32'd2);
    checkOutput("prio_p1_waits", 32'(saw_v1), 32'd0);
    checkOutput("prio_p2_data", memDout2, 32'h3333_4444);
    memRDEN2 = 1'b0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (memValid1) got = 1'b1;
    end
    memRDEN1 = 1'b0;
    checkOutput("prio_p1_done", 32'(got), 32'd1);
    checkOutput("prio_p1_latency", 32'(cyc), 32'd5);
    checkOutput("prio_p1_data", memIR, 32'h1111_2222);

    // Reset asserted while a fetch waits on the SRAM
    ack_delay = 8;
    @(negedge CLK);
    memRDEN1 = 1'b1; memAddr1 = 32'h44;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rst_mid_req_active", 32'(sramReq), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("rst_mid_req_drops", 32'(sramReq), 32'd0);
    checkOutput("rst_mid_no_valid", 32'({memValid1, memValid2}), 32'd0);
    checkOutput("rst_mid_ir_cleared", memIR, 32'd0);
    memRDEN1 = 1'b0;
    @(negedge CLK);
    checkOutput("rst_mid_held_low", 32'({sramReq, memValid1, memValid2}), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("rst_mid_after_release", 32'({sramReq, memValid1, memValid2}), 32'd0);
    ack_delay = 0;
    doAccess("post_reset_fetch", 1'b0, 1'b0, 1'b0, 32'h0000_0044, 2'd2, 1'b0, 32'd0, res);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      p2   = ($urandom_range(0, 3) != 0);
      we   = p2 && ($urandom_range(0, 1) != 0);
      rd   = we ? ($urandom_range(0, 1) != 0) : 1'b1;
      size = 2'($urandom_range(0, 3));
      sgn  = ($urandom_range(0, 1) != 0);
      din  = $urandom;
      cat  = $urandom_range(0, 9);
      if (cat < 6)      addr = 32'($urandom_range(0, 1023));
      else if (cat < 7) addr = 32'($urandom_range(0, MEM_BYTES - 1));
      else if (cat < 8) addr = IO_BASE + 32'($urandom_range(0, 255));
      else if (cat < 9) addr = 32'h0001_0000 + 32'($urandom_range(0, 32'h00FF_FFFF));
      else              addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (!p2)               addr = addr & ~32'd3;
        else if (size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
      end
      ack_delay = $urandom_range(0, 3);
      ioIn      = $urandom;
      doAccess("rand", p2, rd, we, addr, size, sgn, din, res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
